// File: rtl/conv_pe_pkg.sv
// Shared constants, types and helpers for the streaming 3x3 convolution PE.
package conv_pe_pkg;

  localparam int unsigned K      = 3;
  localparam int unsigned NCOEF  = K * K;
  localparam int unsigned DW_DEF = 2;

  // Flattened filter vector at the default pixel width; k[r][c] sits at coef_idx(r,c)*DW.
  typedef logic [NCOEF*DW_DEF-1:0] filt_vec_t;

  function automatic int unsigned acc_width(input int unsigned dw);
    return 2 * dw + 4;
  endfunction

  function automatic int unsigned coef_idx(input int unsigned r, input int unsigned c);
    return K * r + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line buffer: each write pushes the older row's pixel up and stores the new one.
module conv_line_buffer #(
  parameter int unsigned DW    = 2,
  parameter int unsigned IMG_W = 5,
  parameter int unsigned AW    = $clog2(IMG_W)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] col_i,
  input  logic [DW-1:0] pix_i,
  output logic [DW-1:0] lb0_o,
  output logic [DW-1:0] lb1_o
);

  logic [DW-1:0] mem0_q [IMG_W];
  logic [DW-1:0] mem1_q [IMG_W];

  assign lb0_o = mem0_q[col_i];
  assign lb1_o = mem1_q[col_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem1_q[col_i] <= mem0_q[col_i];
      mem0_q[col_i] <= pix_i;
    end
  end

endmodule

// File: rtl/conv3x3_stream_pe.sv
// Streaming 3x3 convolution PE: raster-order pixel input, line buffers, 3x3 window,
// MAC tree and a single registered valid/ready output stage.
module conv3x3_stream_pe
  import conv_pe_pkg::*;
#(
  parameter int unsigned DW     = 2,
  parameter int unsigned IMG_W  = 5,
  parameter int unsigned IMG_H  = 5,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned ACC_W  = acc_width(DW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               filt_load,
  input  logic [9*DW-1:0]    filt_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_pixel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [DW-1:0]       win_q [K][K];
  logic [DW-1:0]       win_d [K][K];
  logic [9*DW-1:0]     filt_q;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [ACC_W-1:0]    out_data_q, out_data_d;
  logic [ACC_W-1:0]    acc;
  logic [DW-1:0]       lb0, lb1;
  logic                accept, col_end, row_end, stride_ok, emit;

  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign col_end   = (col_q == CW'(IMG_W - 1));
  assign row_end   = (row_q == RW'(IMG_H - 1));
  // Stride is 1 or 2; for 2, (x-2)%2==0 reduces to x being even.
  assign stride_ok = (STRIDE == 1) || (!row_q[0] && !col_q[0]);
  assign emit      = accept && (row_q >= RW'(2)) && (col_q >= CW'(2)) && stride_ok;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (col_q != '0) || (row_q != '0) || out_valid_q;

  conv_line_buffer #(
    .DW    (DW),
    .IMG_W (IMG_W)
  ) u_lb (
    .clk_i (clk),
    .we_i  (accept),
    .col_i (col_q),
    .pix_i (in_pixel),
    .lb0_o (lb0),
    .lb1_o (lb1)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][K-1] = lb1;
      win_d[1][K-1] = lb0;
      win_d[2][K-1] = in_pixel;
    end
  end

  // MAC over the post-shift window so the result registers on the accepting edge.
  always_comb begin
    acc = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        acc = acc + ACC_W'(win_d[r][c]) * ACC_W'(filt_q[coef_idx(r, c)*DW +: DW]);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = acc;
      out_last_d  = row_end && col_end;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '{default: '0};
      filt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      if (filt_load && !busy) begin
        filt_q <= filt_in;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_pe.sv
// Directed bench for conv3x3_stream_pe: 5x5/stride-1 instance plus a 7x7/stride-2 instance.
module tb_conv3x3_stream_pe;
  import conv_pe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       filt_load, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  filt_vec_t  filt_in;
  logic [1:0] in_pixel;
  logic [7:0] out_data;

  logic       filt_load2, in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
  filt_vec_t  filt_in2;
  logic [1:0] in_pixel2;
  logic [7:0] out_data2;

  conv3x3_stream_pe #(.DW(2), .IMG_W(5), .IMG_H(5), .STRIDE(1), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .filt_load(filt_load), .filt_in(filt_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  conv3x3_stream_pe #(.DW(2), .IMG_W(7), .IMG_H(7), .STRIDE(2), .ACC_W(8)) dut2 (
    .clk(clk), .rst(rst), .filt_load(filt_load2), .filt_in(filt_in2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_pixel(in_pixel2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .busy(busy2)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  localparam filt_vec_t F_ID   = 18'h00100;
  localparam filt_vec_t F_ALL3 = 18'h3FFFF;
  localparam filt_vec_t F_ONES = 18'h15555;

  logic [1:0] img_id  [25] = '{1,1,0,1,1, 0,0,1,0,0, 1,1,1,1,1, 0,1,0,0,0, 1,1,0,1,0};
  logic [7:0] exp_id  [9]  = '{0,1,0,1,1,1,1,0,0};
  logic [7:0] exp_str [9]  = '{14,12,14,12,14,12,14,12,14};

  logic [7:0] qd[$];
  bit         ql[$];
  logic [7:0] qd2[$];
  bit         ql2[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      qd.push_back(out_data);
      ql.push_back(out_last);
    end
    if (!rst && out_valid2 && out_ready2) begin
      qd2.push_back(out_data2);
      ql2.push_back(out_last2);
    end
  end

  task automatic push(input logic [1:0] p);
    bit ok = 1'b0;
    int unsigned n = 0;
    in_valid = 1'b1;
    in_pixel = p;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL push_timeout: pixel not accepted, in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic push2(input logic [1:0] p);
    bit ok = 1'b0;
    int unsigned n = 0;
    in_valid2 = 1'b1;
    in_pixel2 = p;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready2;
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL push2_timeout: pixel not accepted, in_ready=%0b required 1", in_ready2);
    end
  endtask

  task automatic send_img(input logic [1:0] img [25]);
    for (int i = 0; i < 25; i++) push(img[i]);
  endtask

  task automatic load_filter(input filt_vec_t f);
    filt_in = f;
    filt_load = 1'b1;
    @(posedge clk); #1;
    filt_load = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    filt_load = 1'b0; filt_in = '0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
    filt_load2 = 1'b0; filt_in2 = '0; in_valid2 = 1'b0; in_pixel2 = '0; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors += 5;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b want 0", busy); end
    if (out_data !== 8'd0) begin miscompares++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
    if (out_last !== 1'b0) begin miscompares++; $display("FAIL rst_out_last: got %0b want 0", out_last); end
    rst = 1'b0;
    #1;
    vectors += 2;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready: got %0b want 1", in_ready); end
    if (out_valid2 !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid2: got %0b want 0", out_valid2); end
  endtask

  task automatic test_identity();
    load_filter(F_ID);
    qd.delete(); ql.delete();
    send_img(img_id);
    drain();
    vectors++;
    if (qd.size() != 9) begin miscompares++; $display("FAIL id_count: got %0d want 9", qd.size()); end
    for (int i = 0; i < 9 && i < qd.size(); i++) begin
      vectors += 2;
      if (qd[i] !== exp_id[i]) begin miscompares++; $display("FAIL id_data[%0d]: got %0d want %0d", i, qd[i], exp_id[i]); end
      if (ql[i] !== (i == 8)) begin miscompares++; $display("FAIL id_last[%0d]: got %0b want %0b", i, ql[i], (i == 8)); end
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL id_busy_end: got %0b want 0", busy); end
  endtask

  task automatic test_worst_case();
    logic [1:0] img3 [25];
    for (int i = 0; i < 25; i++) img3[i] = 2'd3;
    load_filter(F_ALL3);
    qd.delete(); ql.delete();
    send_img(img3);
    drain();
    vectors++;
    if (qd.size() != 9) begin miscompares++; $display("FAIL worst_count: got %0d want 9", qd.size()); end
    for (int i = 0; i < 9 && i < qd.size(); i++) begin
      vectors += 2;
      if (qd[i] !== 8'd81) begin miscompares++; $display("FAIL worst_data[%0d]: got %0d want 81", i, qd[i]); end
      if (ql[i] !== (i == 8)) begin miscompares++; $display("FAIL worst_last[%0d]: got %0b want %0b", i, ql[i], (i == 8)); end
    end
  endtask

  task automatic test_backpressure();
    load_filter(F_ID);
    qd.delete(); ql.delete();
    fork
      send_img(img_id);
      begin
        int unsigned n = 0;
        logic [7:0] d0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        vectors++;
        if (!out_valid) begin
          miscompares++;
          $display("FAIL bp_wait_valid: out_valid=%0b required 1", out_valid);
        end else begin
          out_ready = 1'b0;
          d0 = out_data;
          #1;
          for (int k = 0; k < 4; k++) begin
            vectors += 3;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, in_ready); end
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", k, out_valid); end
            if (out_data !== d0) begin miscompares++; $display("FAIL bp_hold[%0d]: got %0d want %0d", k, out_data, d0); end
            @(posedge clk); #2;
          end
        end
        out_ready = 1'b1;
      end
    join
    drain();
    vectors++;
    if (qd.size() != 9) begin miscompares++; $display("FAIL bp_count: got %0d want 9", qd.size()); end
    for (int i = 0; i < 9 && i < qd.size(); i++) begin
      vectors += 2;
      if (qd[i] !== exp_id[i]) begin miscompares++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, qd[i], exp_id[i]); end
      if (ql[i] !== (i == 8)) begin miscompares++; $display("FAIL bp_last[%0d]: got %0b want %0b", i, ql[i], (i == 8)); end
    end
  endtask

  task automatic test_stride2();
    filt_in2 = F_ONES;
    filt_load2 = 1'b1;
    @(posedge clk); #1;
    filt_load2 = 1'b0;
    qd2.delete(); ql2.delete();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        push2(2'((r + c) % 4));
    in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (qd2.size() != 9) begin miscompares++; $display("FAIL s2_count: got %0d want 9", qd2.size()); end
    for (int i = 0; i < 9 && i < qd2.size(); i++) begin
      vectors += 2;
      if (qd2[i] !== exp_str[i]) begin miscompares++; $display("FAIL s2_data[%0d]: got %0d want %0d", i, qd2[i], exp_str[i]); end
      if (ql2[i] !== (i == 8)) begin miscompares++; $display("FAIL s2_last[%0d]: got %0b want %0b", i, ql2[i], (i == 8)); end
    end
  endtask

  task automatic test_filter_reset();
    load_filter(F_ID);
    for (int i = 0; i < 13; i++) begin
      if (i == 3) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL fr_busy_mid: got %0b want 1", busy); end
        filt_in = F_ALL3;
        filt_load = 1'b1;
      end
      push(img_id[i]);
      filt_load = 1'b0;
    end
    // Identity keeps centre (1,1)=0; an all-3 filter would have given 18.
    vectors += 2;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fr_px12_valid: got %0b want 1", out_valid); end
    if (out_data !== 8'd0) begin miscompares++; $display("FAIL fr_px12_data: got %0d want 0", out_data); end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fr_rst_valid: got %0b want 0", out_valid); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL fr_rst_busy: got %0b want 0", busy); end
    if (out_data !== 8'd0) begin miscompares++; $display("FAIL fr_rst_data: got %0d want 0", out_data); end
    qd.delete(); ql.delete();
    send_img(img_id);
    drain();
    vectors++;
    if (qd.size() != 9) begin miscompares++; $display("FAIL fr_zero_count: got %0d want 9", qd.size()); end
    for (int i = 0; i < 9 && i < qd.size(); i++) begin
      vectors++;
      if (qd[i] !== 8'd0) begin miscompares++; $display("FAIL fr_zero_data[%0d]: got %0d want 0", i, qd[i]); end
    end
    load_filter(F_ID);
    qd.delete(); ql.delete();
    send_img(img_id);
    drain();
    vectors++;
    if (qd.size() != 9) begin miscompares++; $display("FAIL fr_reload_count: got %0d want 9", qd.size()); end
    for (int i = 0; i < 9 && i < qd.size(); i++) begin
      vectors++;
      if (qd[i] !== exp_id[i]) begin miscompares++; $display("FAIL fr_reload_data[%0d]: got %0d want %0d", i, qd[i], exp_id[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned c0;
    qd.delete(); ql.delete();
    c0 = cyc;
    send_img(img_id);
    send_img(img_id);
    vectors++;
    if (cyc - c0 != 50) begin miscompares++; $display("FAIL b2b_cycles: got %0d want 50", cyc - c0); end
    drain();
    vectors++;
    if (qd.size() != 18) begin miscompares++; $display("FAIL b2b_count: got %0d want 18", qd.size()); end
    for (int i = 0; i < 18 && i < qd.size(); i++) begin
      vectors += 2;
      if (qd[i] !== exp_id[i % 9]) begin miscompares++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, qd[i], exp_id[i % 9]); end
      if (ql[i] !== (i == 8 || i == 17)) begin miscompares++; $display("FAIL b2b_last[%0d]: got %0b want %0b", i, ql[i], (i == 8 || i == 17)); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_worst_case();
    test_backpressure();
    test_stride2();
    test_filter_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
